axis_sample_source: RTL and testbench

AXIS_SAMPLE_SOURCE -- requirements
Module: axis_sample_source

---
 rtl/axis_sample_source.sv | 113 +++++++++++
 tb/tb_axis_sample_source.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/axis_sample_source.sv
// rtl/axis_sample_source.sv - offset-binary ADC sample to AXI-Stream source with small FIFO
// Overflow drops the newest sample; a pop in the same cycle makes room for it instead.
module axis_sample_source #(
  parameter int ADC_W = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     adc_valid,
  input  logic [ADC_W-1:0]         adc_data,
  input  logic                     clear_ovf,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [31:0]              m_axis_tdata,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  logic [ADC_W-1:0] flipped;
  logic [31:0]      sample;
  logic             accept;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  // Flipping the MSB turns offset-binary into two's complement of the same width.
  assign flipped = {~adc_data[ADC_W-1], adc_data[ADC_W-2:0]};
  assign sample  = 32'($signed(flipped));

  assign accept = adc_valid & en;
  assign full   = (fill_q == FULL_CNT);
  assign pop    = m_axis_tvalid & m_axis_tready;
  assign push   = accept & (~full | pop);
  assign drop   = accept & full & ~pop;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = sample;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      fill_d = fill_q + CNT_W'(1);
    end else if (pop && !push) begin
      fill_d = fill_q - CNT_W'(1);
    end

    // A drop coinciding with a clear restarts the count at one rather than zero.
    if (drop) begin
      overflow_d = 1'b1;
      if (clear_ovf) begin
        drop_cnt_d = 16'd1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end else if (clear_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: fill_q gates everything visible from it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign m_axis_tvalid = (fill_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? mem_q[rd_ptr_q] : 32'd0;
  assign fill          = fill_q;
  assign overflow      = overflow_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_axis_sample_source.sv
// tb/tb_axis_sample_source.sv - directed self-checking bench for axis_sample_source
module tb_axis_sample_source;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        adc_valid;
  logic [11:0] adc_data;
  logic        clear_ovf;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [2:0]  fill;
  logic        overflow;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] bp_exp [4] = '{32'hFFFFF800, 32'h000007FF, 32'h00000000, 32'hFFFFFFFF};
  logic [11:0] bp_in  [4] = '{12'h000, 12'hFFF, 12'h800, 12'h7FF};
  logic [31:0] fp_exp [4] = '{32'hFFFFF802, 32'hFFFFF803, 32'hFFFFF804, 32'hFFFFF810};

  axis_sample_source #(.ADC_W(12), .DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .adc_valid     (adc_valid),
    .adc_data      (adc_data),
    .clear_ovf     (clear_ovf),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .fill          (fill),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    en            = 1'b0;
    adc_valid     = 1'b0;
    adc_data      = 12'h000;
    clear_ovf     = 1'b0;
    m_axis_tready = 1'b0;

    repeat (2) step();
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tdata", m_axis_tdata, 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);

    // single sample, accepted on the first edge after release
    rst_n = 1'b1;
    en = 1'b1; m_axis_tready = 1'b1; adc_valid = 1'b1; adc_data = 12'h9A3;
    step();
    adc_valid = 1'b0;
    check("single_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("single_tdata", m_axis_tdata, 32'h000001A3);
    check("single_fill", 32'(fill), 32'd1);
    step();
    check("single_tvalid_after", 32'(m_axis_tvalid), 32'd0);
    check("single_fill_after", 32'(fill), 32'd0);

    // backpressure
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      adc_valid = 1'b1; adc_data = bp_in[i];
      step();
    end
    adc_valid = 1'b0;
    check("bp_fill", 32'(fill), 32'd4);
    step();
    check("bp_hold_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("bp_hold_tdata", m_axis_tdata, 32'hFFFFF800);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_out%0d", i), m_axis_tdata, bp_exp[i]);
      step();
    end
    check("bp_drained", 32'(m_axis_tvalid), 32'd0);

    // overflow and clear
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      adc_valid = 1'b1; adc_data = 12'(i);
      step();
    end
    adc_valid = 1'b0;
    check("ovf_fill", 32'(fill), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_drop", 32'(drop_cnt), 32'd2);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    check("clr_flag", 32'(overflow), 32'd0);
    check("clr_drop", 32'(drop_cnt), 32'd0);
    check("clr_fill", 32'(fill), 32'd4);
    check("clr_head", m_axis_tdata, 32'hFFFFF801);

    // full FIFO with simultaneous push and pop
    m_axis_tready = 1'b1; adc_valid = 1'b1; adc_data = 12'h010;
    step();
    adc_valid = 1'b0;
    check("pp_fill", 32'(fill), 32'd4);
    check("pp_drop", 32'(drop_cnt), 32'd0);
    check("pp_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pp_out%0d", i), m_axis_tdata, fp_exp[i]);
      step();
    end
    check("pp_drained", 32'(fill), 32'd0);

    // en=0 ignores strobes
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      adc_valid = 1'b1; adc_data = 12'(i * 256);
      step();
    end
    en = 1'b0;
    repeat (3) step();
    adc_valid = 1'b0;
    check("en0_fill", 32'(fill), 32'd3);
    check("en0_head", m_axis_tdata, 32'hFFFFF900);

    // asynchronous reset mid-transfer, between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("arst_fill", 32'(fill), 32'd0);
    check("arst_tdata", m_axis_tdata, 32'd0);
    step();
    rst_n = 1'b1;
    en = 1'b1; adc_valid = 1'b1; adc_data = 12'hABC;
    step();
    adc_valid = 1'b0;
    check("post_rst_fill", 32'(fill), 32'd1);
    check("post_rst_tdata", m_axis_tdata, 32'h000002BC);
    m_axis_tready = 1'b1;
    step();
    check("post_rst_drained", 32'(fill), 32'd0);

    // saturation: 4 pushes then 65540 drops
    m_axis_tready = 1'b0; adc_valid = 1'b1; adc_data = 12'h555;
    repeat (4 + 65540) step();
    check("sat_drop", 32'(drop_cnt), 32'h0000FFFF);
    check("sat_ovf", 32'(overflow), 32'd1);
    clear_ovf = 1'b1;
    step();
    check("sat_clr_drop_ovf", 32'(overflow), 32'd1);
    check("sat_clr_drop_cnt", 32'(drop_cnt), 32'd1);
    adc_valid = 1'b0;
    step();
    clear_ovf = 1'b0;
    check("sat_clr_ovf", 32'(overflow), 32'd0);
    check("sat_clr_cnt", 32'(drop_cnt), 32'd0);
    check("sat_fill", 32'(fill), 32'd4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
